controlador_turnos: RTL and testbench
=====================================

Name: controlador_turnos

Overview:
Turn-control FSM that drives the 10-second turn countdown timer and consumes its status. It arms and restarts the timer at each turn and gates its enable. It accepts the current player's move or, on timeout, requests an automatic move. It alternates players and declares a forfeit after repeated consecutive timeouts. It sits between the game-logic/move-input blocks and the countdown timer, one instance per game board.

Parameters:
MAX_TIMEOUTS, 3, consecutive timeouts by one player that cause forfeit (1..7)
WARN_SECS, 3, alerta asserted while remaining seconds <= this value (0..9)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins/restarts a game (honoured in IDLE and DONE only)
game_over  input  1  level from game logic; game finished by win/draw
jugada_valida  input  1  one-cycle pulse; current player committed a legal move
tiempo_agotado  input  1  countdown timer expired flag
segundos_restantes  input  4  countdown timer remaining seconds (0..10)
auto_done  input  1  one-cycle pulse; automatic-move generator finished
timer_reset  output  1  drives countdown timer reset (registered)
timer_enable  output  1  drives countdown timer enable
jugador  output  1  current player: 0 = P1, 1 = P2
turno_activo  output  1  moves accepted this cycle
auto_req  output  1  automatic-move request, held until auto_done
alerta  output  1  low-time warning
forfeit  output  1  game ended by timeout forfeit
ganador  output  1  winning player, valid when forfeit = 1

Behaviour:
- States: IDLE, ARM, RUN, AUTO, SWITCH, DONE. Moore outputs, all registered except alerta.
- Reset (async) state and outputs:
  - State = IDLE, jugador = 0, both timeout counters = 0.
  - forfeit = 0, ganador = 0, timer_reset = 1.
  - timer_enable = 0, turno_activo = 0, auto_req = 0.
- Output decode:
  - timer_reset = 1 in IDLE and ARM, else 0.
  - timer_enable = 1 and turno_activo = 1 only in RUN.
  - auto_req = 1 only in AUTO.
  - alerta = (state == RUN) && (segundos_restantes <= WARN_SECS) && !tiempo_agotado; combinational.
- IDLE: start -> ARM.
- ARM: exactly 1 cycle -> RUN. Timer is therefore at 10 s when RUN begins.
- RUN, priority order:
  - 1. game_over -> DONE.
  - 2. jugada_valida -> clear counter[jugador]; -> SWITCH.
  - 3. tiempo_agotado -> counter[jugador] + 1. If the new value == MAX_TIMEOUTS -> DONE with forfeit <= 1, ganador <= ~jugador. Otherwise -> AUTO.
  - A move and a timeout in the same cycle: the move wins; the counter is cleared, not incremented.
- AUTO:
  - jugada_valida is ignored.
  - auto_done -> SWITCH.
  - game_over -> DONE, with priority over auto_done.
  - Timer remains disabled and frozen at 0.
- SWITCH: 1 cycle; jugador <= ~jugador; -> ARM. game_over -> DONE, without toggling.
- DONE:
  - All turn outputs are low and timer_reset = 0, so the display freezes.
  - forfeit and ganador are held.
  - start -> ARM, with jugador <= 0, counters <= 0, forfeit <= 0, ganador <= 0.
- game_over in ARM -> DONE. game_over is ignored in IDLE.
- start outside IDLE/DONE is ignored.
- Latency: jugada_valida in cycle N (RUN) gives SWITCH at N+1, ARM at N+2 with new jugador, RUN at N+3.
- Counters: one 3-bit counter per player. A counter saturates only at MAX_TIMEOUTS because a forfeit ends the game there. The opponent's counter is unaffected by the current player's events.
- Reset mid-operation: immediate return to the reset values; the timer is held in reset by timer_reset = 1.

Test Plan:
- Reset asserted mid-RUN -> next edge: state IDLE, timer_reset = 1, timer_enable = 0, jugador = 0, forfeit = 0.
- start pulse, then jugada_valida 5 cycles after RUN entry:
  - Sequence is ARM(1) -> RUN (turno_activo = 1, timer_enable = 1).
  - Then SWITCH -> ARM, where jugador = 1 and timer_reset = 1, then RUN.
  - The move-to-RUN span is 3 cycles.
- In RUN with jugador = 0, assert tiempo_agotado:
  - Next cycle: auto_req = 1, timer_enable = 0.
  - auto_req stays 1 for 20 cycles until auto_done.
  - Then SWITCH -> ARM -> RUN with jugador = 1.
- jugada_valida and tiempo_agotado in the same RUN cycle -> SWITCH (no AUTO); counter[jugador] = 0.
- MAX_TIMEOUTS = 3: P1 times out 3 turns in a row while P2 moves normally:
  - After the 3rd timeout: DONE, forfeit = 1, ganador = 1, no auto_req.
  - A valid P1 move after 2 timeouts resets P1's count, so 3 further timeouts are needed.
- segundos_restantes stepped 5, 4, 3, 2, 1, 0 in RUN with WARN_SECS = 3:
  - alerta is 0, 0, 1, 1, 1, and 0 once tiempo_agotado = 1.
  - game_over during AUTO -> DONE, auto_req = 0 next cycle, forfeit = 0.
  - A following start -> ARM with jugador = 0.

Source files
------------

// File: rtl/controlador_turnos.sv
// Turn controller for one game board: arms and gates the 10 s countdown
// timer, accepts the current player's move, requests an automatic move on
// timeout, alternates players and declares a forfeit after repeated
// consecutive timeouts by the same player.
module controlador_turnos #(
  parameter int MAX_TIMEOUTS = 3,
  parameter int WARN_SECS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       game_over,
  input  logic       jugada_valida,
  input  logic       tiempo_agotado,
  input  logic [3:0] segundos_restantes,
  input  logic       auto_done,
  output logic       timer_reset,
  output logic       timer_enable,
  output logic       jugador,
  output logic       turno_activo,
  output logic       auto_req,
  output logic       alerta,
  output logic       forfeit,
  output logic       ganador
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    RUN    = 3'd2,
    AUTO   = 3'd3,
    SWITCH = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            jugador_q, jugador_d;
  logic [1:0][2:0] cnt_q, cnt_d;
  logic            forfeit_q, forfeit_d;
  logic            ganador_q, ganador_d;
  logic            timer_reset_q, timer_enable_q, turno_activo_q, auto_req_q;
  logic [2:0]      cntInc;

  // Next-state and bookkeeping: decides the following phase of the turn,
  // the player to move and each player's consecutive-timeout count.
  always_comb begin
    state_d   = state_q;
    jugador_d = jugador_q;
    cnt_d     = cnt_q;
    forfeit_d = forfeit_q;
    ganador_d = ganador_q;
    cntInc    = cnt_q[jugador_q] + 3'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ARM;
          jugador_d = 1'b0;
          cnt_d     = '0;
          forfeit_d = 1'b0;
          ganador_d = 1'b0;
        end
      end
      ARM: begin
        if (game_over) state_d = DONE;
        else           state_d = RUN;
      end
      RUN: begin
        if (game_over) begin
          state_d = DONE;
        end else if (jugada_valida) begin
          cnt_d[jugador_q] = 3'd0;
          state_d          = SWITCH;
        end else if (tiempo_agotado) begin
          cnt_d[jugador_q] = cntInc;
          if (cntInc == 3'(MAX_TIMEOUTS)) begin
            state_d   = DONE;
            forfeit_d = 1'b1;
            ganador_d = ~jugador_q;
          end else begin
            state_d = AUTO;
          end
        end
      end
      AUTO: begin
        if (game_over)      state_d = DONE;
        else if (auto_done) state_d = SWITCH;
      end
      SWITCH: begin
        if (game_over) begin
          state_d = DONE;
        end else begin
          jugador_d = ~jugador_q;
          state_d   = ARM;
        end
      end
      DONE: begin
        if (start) begin
          state_d   = ARM;
          jugador_d = 1'b0;
          cnt_d     = '0;
          forfeit_d = 1'b0;
          ganador_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state so every turn
  // output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      jugador_q      <= 1'b0;
      cnt_q          <= '0;
      forfeit_q      <= 1'b0;
      ganador_q      <= 1'b0;
      timer_reset_q  <= 1'b1;
      timer_enable_q <= 1'b0;
      turno_activo_q <= 1'b0;
      auto_req_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      jugador_q      <= jugador_d;
      cnt_q          <= cnt_d;
      forfeit_q      <= forfeit_d;
      ganador_q      <= ganador_d;
      timer_reset_q  <= (state_d == IDLE) || (state_d == ARM);
      timer_enable_q <= (state_d == RUN);
      turno_activo_q <= (state_d == RUN);
      auto_req_q     <= (state_d == AUTO);
    end
  end

  assign timer_reset  = timer_reset_q;
  assign timer_enable = timer_enable_q;
  assign turno_activo = turno_activo_q;
  assign auto_req     = auto_req_q;
  assign jugador      = jugador_q;
  assign forfeit      = forfeit_q;
  assign ganador      = ganador_q;

  // The low-time warning follows the timer directly and is silenced once
  // the timer reports expiry.
  assign alerta = (state_q == RUN) && (segundos_restantes <= 4'(WARN_SECS)) && !tiempo_agotado;

endmodule

// File: tb/tb_controlador_turnos.sv
// Self-checking bench for controlador_turnos: a fixed vector table, a few
// hand-written multi-cycle scenarios and a randomized run against a
// turn-level reference model.
module tb_controlador_turnos;

  localparam int MAXT = 3;
  localparam int WARN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic       jugada_valida = 1'b0;
  logic       tiempo_agotado = 1'b0;
  logic [3:0] segundos_restantes = 4'd10;
  logic       auto_done = 1'b0;
  logic       timer_reset, timer_enable, jugador, turno_activo;
  logic       auto_req, alerta, forfeit, ganador;

  int nCmp = 0;
  int nBad = 0;

  // Reference model state, expressed as turn phases and per-player counts.
  string      mPh;
  int         mJug;
  int         mTo[2];
  int         mFf;
  int         mGan;
  logic       lastTa;
  logic [3:0] lastSecs;

  typedef struct {
    logic       st;
    logic       go;
    logic       jv;
    logic       ta;
    logic [3:0] secs;
    logic       ad;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[21];

  controlador_turnos #(.MAX_TIMEOUTS(MAXT), .WARN_SECS(WARN)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .game_over(game_over),
    .jugada_valida(jugada_valida),
    .tiempo_agotado(tiempo_agotado),
    .segundos_restantes(segundos_restantes),
    .auto_done(auto_done),
    .timer_reset(timer_reset),
    .timer_enable(timer_enable),
    .jugador(jugador),
    .turno_activo(turno_activo),
    .auto_req(auto_req),
    .alerta(alerta),
    .forfeit(forfeit),
    .ganador(ganador)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] dutVec();
    return {timer_reset, timer_enable, jugador, turno_activo, auto_req, forfeit, ganador, alerta};
  endfunction

  function automatic logic [7:0] modelVec();
    logic tr, te, ar, al;
    tr = (mPh == "IDLE") || (mPh == "ARM");
    te = (mPh == "RUN");
    ar = (mPh == "AUTO");
    al = (mPh == "RUN") && (int'(lastSecs) <= WARN) && !lastTa;
    return {tr, te, 1'(mJug), te, ar, 1'(mFf), 1'(mGan), al};
  endfunction

  function automatic vec_t mk(input logic st, input logic go, input logic jv, input logic ta,
                              input int secs, input logic ad, input logic [7:0] e);
    vec_t v;
    v.st = st; v.go = go; v.jv = jv; v.ta = ta;
    v.secs = 4'(secs); v.ad = ad; v.exp = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %b, wanted %b (tr te jug turno areq ff gan alerta)", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %b, wanted %b", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPh = "IDLE"; mJug = 0; mTo[0] = 0; mTo[1] = 0; mFf = 0; mGan = 0;
  endtask

  task automatic modelNewGame();
    mPh = "ARM"; mJug = 0; mTo[0] = 0; mTo[1] = 0; mFf = 0; mGan = 0;
  endtask

  // One clock of the turn rules as written in the game description.
  task automatic modelStep(input logic st, input logic go, input logic jv, input logic ta, input logic ad);
    if (mPh == "IDLE") begin
      if (st) modelNewGame();
    end else if (mPh == "ARM") begin
      mPh = go ? "DONE" : "RUN";
    end else if (mPh == "RUN") begin
      if (go) begin
        mPh = "DONE";
      end else if (jv) begin
        mTo[mJug] = 0;
        mPh = "SWITCH";
      end else if (ta) begin
        mTo[mJug] = mTo[mJug] + 1;
        if (mTo[mJug] == MAXT) begin
          mPh = "DONE"; mFf = 1; mGan = 1 - mJug;
        end else begin
          mPh = "AUTO";
        end
      end
    end else if (mPh == "AUTO") begin
      if (go) mPh = "DONE";
      else if (ad) mPh = "SWITCH";
    end else if (mPh == "SWITCH") begin
      if (go) begin
        mPh = "DONE";
      end else begin
        mJug = 1 - mJug;
        mPh = "ARM";
      end
    end else begin
      if (st) modelNewGame();
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge and compare.
  task automatic applyStimulus(input logic st, input logic go, input logic jv, input logic ta,
                               input logic [3:0] secs, input logic ad, input logic rst);
    reset = rst; start = st; game_over = go; jugada_valida = jv;
    tiempo_agotado = ta; segundos_restantes = secs; auto_done = ad;
    @(posedge clk);
    if (rst) modelReset();
    else modelStep(st, go, jv, ta, ad);
    lastTa = ta; lastSecs = secs;
    #1;
    checkOutput("model", dutVec(), modelVec());
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b1);
  endtask

  task automatic beginGame();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
    idle();
  endtask

  task automatic moveTurn();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
    idle();
    idle();
  endtask

  task automatic finishAuto();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    idle();
    idle();
  endtask

  task automatic timeoutPulse();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic st, go, jv, ta, ad, rst;
    logic [3:0] secs;
    modelReset();
    lastTa = 1'b0; lastSecs = 4'd10;

    // Fixed vectors: {start, game_over, move, timeout, secs, auto_done, expected}.
    tbl[0]  = mk(1, 0, 0, 0, 10, 0, 8'b1000_0000);
    tbl[1]  = mk(0, 0, 0, 0, 10, 0, 8'b0101_0000);
    tbl[2]  = mk(0, 0, 0, 0, 10, 0, 8'b0101_0000);
    tbl[3]  = mk(0, 0, 0, 0, 10, 0, 8'b0101_0000);
    tbl[4]  = mk(0, 0, 0, 0, 10, 0, 8'b0101_0000);
    tbl[5]  = mk(0, 0, 0, 0, 10, 0, 8'b0101_0000);
    tbl[6]  = mk(0, 0, 1, 0, 6, 0, 8'b0000_0000);
    tbl[7]  = mk(0, 0, 0, 0, 10, 0, 8'b1010_0000);
    tbl[8]  = mk(0, 0, 0, 0, 10, 0, 8'b0111_0000);
    tbl[9]  = mk(0, 0, 0, 0, 5, 0, 8'b0111_0000);
    tbl[10] = mk(0, 0, 0, 0, 3, 0, 8'b0111_0001);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 8'b0010_1000);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 8'b0010_0000);
    tbl[13] = mk(0, 0, 0, 0, 10, 0, 8'b1000_0000);
    tbl[14] = mk(0, 0, 0, 0, 10, 0, 8'b0101_0000);
    tbl[15] = mk(0, 0, 1, 1, 0, 0, 8'b0000_0000);
    tbl[16] = mk(0, 0, 0, 0, 10, 0, 8'b1010_0000);
    tbl[17] = mk(0, 0, 0, 0, 10, 0, 8'b0111_0000);
    tbl[18] = mk(0, 1, 0, 0, 10, 0, 8'b0010_0000);
    tbl[19] = mk(1, 0, 0, 0, 10, 0, 8'b1000_0000);
    tbl[20] = mk(1, 0, 0, 0, 10, 0, 8'b0101_0000);

    doReset();
    checkOutput("reset_state", dutVec(), 8'b1000_0000);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(tbl[i].st, tbl[i].go, tbl[i].jv, tbl[i].ta, tbl[i].secs, tbl[i].ad, 1'b0);
      checkOutput($sformatf("vec%0d", i), dutVec(), tbl[i].exp);
    end

    // Reset in the middle of P2's running turn.
    doReset();
    beginGame();
    moveTurn();
    checkBit("pre_reset_jug", jugador, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1);
    checkBit("rst_timer_reset", timer_reset, 1'b1);
    checkBit("rst_timer_enable", timer_enable, 1'b0);
    checkBit("rst_jugador", jugador, 1'b0);
    checkBit("rst_forfeit", forfeit, 1'b0);

    // Timeout: automatic move request held until the generator finishes.
    doReset();
    beginGame();
    timeoutPulse();
    checkBit("to_auto_req", auto_req, 1'b1);
    checkBit("to_timer_en", timer_enable, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, i[0], 1'b0, 4'd0, 1'b0, 1'b0);
      checkBit($sformatf("auto_hold%0d", i), auto_req, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkBit("auto_done_sw", auto_req, 1'b0);
    idle();
    checkBit("auto_arm_jug", jugador, 1'b1);
    checkBit("auto_arm_trst", timer_reset, 1'b1);
    idle();
    checkBit("auto_run_en", timer_enable, 1'b1);

    // Forfeit: P1 times out repeatedly; a P1 move in between clears the count.
    doReset();
    beginGame();
    timeoutPulse(); finishAuto();
    moveTurn();
    timeoutPulse();
    checkBit("p1_second_to_auto", auto_req, 1'b1);
    checkBit("p1_second_to_noff", forfeit, 1'b0);
    finishAuto();
    moveTurn();
    moveTurn();
    moveTurn();
    timeoutPulse();
    checkBit("p1_count_cleared", auto_req, 1'b1);
    finishAuto();
    moveTurn();
    timeoutPulse(); finishAuto();
    moveTurn();
    timeoutPulse();
    checkBit("ff_forfeit", forfeit, 1'b1);
    checkBit("ff_ganador", ganador, 1'b1);
    checkBit("ff_auto_req", auto_req, 1'b0);
    checkBit("ff_timer_reset", timer_reset, 1'b0);
    idle(); idle();
    checkBit("ff_held", forfeit, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
    checkBit("ff_restart_clear", forfeit, 1'b0);
    checkBit("ff_restart_jug", jugador, 1'b0);

    // Warning threshold while the seconds count down.
    idle();
    for (int s = 5; s >= 0; s--) begin
      applyStimulus(1'b0, 1'b0, 1'b0, (s == 0), 4'(s), 1'b0, 1'b0);
      checkBit($sformatf("alerta_s%0d", s), alerta, (s <= WARN) && (s != 0));
    end

    // Game over during the automatic move.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkBit("go_auto_req", auto_req, 1'b0);
    checkBit("go_forfeit", forfeit, 1'b0);
    checkBit("go_timer_reset", timer_reset, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
    checkBit("go_restart_jug", jugador, 1'b0);
    checkBit("go_restart_trst", timer_reset, 1'b1);

    // Randomized traffic checked against the reference model.
    doReset();
    for (int i = 0; i < 4000; i++) begin
      st   = ($urandom_range(99) < 6);
      go   = ($urandom_range(99) < 2);
      jv   = ($urandom_range(99) < 10);
      ta   = ($urandom_range(99) < 9);
      ad   = ($urandom_range(99) < 12);
      rst  = ($urandom_range(999) < 3);
      secs = 4'($urandom_range(10));
      applyStimulus(st, go, jv, ta, secs, ad, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
